mul_datapath: RTL and testbench
===============================

MUL_DATAPATH -- requirements
Module: mul_datapath

Interface
REQ-001 The block SHALL have one parameter, W, default 16, meaning the operand width in bits; the product width is 2*W.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 data_in  input  W  shared operand bus, loaded into A or B.
REQ-005 LdA  input  1  load register A from data_in.
REQ-006 LdB  input  1  load counter B from data_in.
REQ-007 LdP  input  1  accumulate enable: P <= P + A.
REQ-008 clrP  input  1  clear P, ovf and iter_cnt.
REQ-009 decB  input  1  decrement counter B.
REQ-010 eqz  output  1  combinational flag, high when B == 0; the flag goes to the sequencing controller.
REQ-011 product  output  2*W  current value of register P.
REQ-012 ovf  output  1  sticky flag set when an accumulate carries out of 2*W bits.
REQ-013 iter_cnt  output  W  number of accumulates performed since the last clrP, saturating at all-ones.

Function
REQ-014 A SHALL load data_in when LdA=1; otherwise A SHALL hold.
REQ-015 B SHALL load data_in when LdB=1, irrespective of decB (LdB has priority).
REQ-016 When decB=1 and LdB=0, B SHALL decrement by 1 only if B != 0; at B == 0, B SHALL hold 0 (no wrap to all-ones).
REQ-017 eqz SHALL equal (B == 0), evaluated combinationally from the registered B, with no added cycle of latency.
REQ-018 When clrP=1, P, ovf and iter_cnt SHALL all go to 0 at the next edge; clrP SHALL have priority over LdP.
REQ-019 An accumulate SHALL occur only when LdP=1, clrP=0 and eqz=0 (B != 0, sampled before the edge).
  - On an accumulate: P <= P + A, with the result truncated to 2*W bits.
  - When LdP=1 while B == 0, P SHALL hold. This guard keeps the controller's final LdP cycle from adding A one extra time.
REQ-020 An accumulate SHALL use the value A holds before the edge; a simultaneous LdA SHALL affect only later accumulates.
REQ-021 When the 2*W+1-bit sum P + A exceeds 2^(2*W) - 1 on an accumulate, ovf SHALL set; once set, ovf SHALL hold until clrP or reset.
REQ-022 iter_cnt SHALL increment on each accumulate and SHALL saturate at 2^W - 1.
REQ-023 Under the controller's standard sequence, the accumulate guard SHALL give a final product equal to A*B exactly:
  - LdA;
  - then LdB with clrP;
  - then LdP with decB, repeated until eqz.
  - This SHALL hold for every operand pair, including B = 0 (product 0, iter_cnt 0) and A = 0.
REQ-024 The block SHALL use only non-blocking register updates and SHALL contain no # delays.
REQ-025 All control inputs SHALL be independent; any combination in the same cycle SHALL resolve as specified by REQ-014 to REQ-022 alone.

Reset
REQ-026 When rst_n=0 at a rising edge, A, B, P, ovf and iter_cnt SHALL all go to 0, and all control inputs in that cycle SHALL be ignored.
REQ-027 After reset, eqz SHALL be 1 and product SHALL be 0.
REQ-028 A reset asserted mid-multiplication SHALL abort the operation at the next edge with the full reset state; no partial result SHALL be retained.

Verification
REQ-029 Basic multiply, W=16:
  - Stimulus: LdA with data_in=7; next cycle, LdB+clrP with data_in=5; then LdP+decB held for 6 cycles.
  - Response: product=35, iter_cnt=5, ovf=0, eqz=1 after the 5th cycle; the 6th cycle does not change P.
REQ-030 Zero multiplier:
  - Stimulus: A=9, B=0, LdP+decB held for 3 cycles.
  - Response: eqz=1 throughout, product=0, iter_cnt=0, B stays 0.
REQ-031 Overflow, W=16:
  - Stimulus: A=16'hFFFF, B=16'hFFFF, run until eqz, then one extra accumulate attempt.
  - Response: product=32'hFFFE0001 (A*B, no overflow), ovf=0.
  - Follow-up: force an accumulate with P=32'hFFFFFFFF, A=1, B=1 (for example, preload by running the sequence).
  - Required response: P=0, ovf=1 and held.
REQ-032 Priority:
  - LdB=1 and decB=1 with data_in=4 and B=9 -> B=4.
  - clrP=1 and LdP=1 with A=3 -> P=0 and iter_cnt=0.
  - LdA=1 (data_in=8) and LdP=1 with old A=2 and B=1 -> P grows by 2, and A=8 afterwards.
REQ-033 Reset mid-run:
  - Stimulus: A=3, B=10; after 4 accumulates (P=12), drive rst_n=0 for one edge.
  - Response: A=B=P=0, ovf=0, iter_cnt=0, eqz=1 at that edge; a subsequent 2x6 sequence yields 12.

Source files
------------

// File: rtl/mul_datapath.sv
// Shift-free repeated-addition multiplier datapath: A operand, B down-counter,
// P accumulator with sticky carry-out flag and saturating accumulate count.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   data_in [W-1:0]   shared operand bus for A and B
//   LdA, LdB          load A / B from data_in (LdB beats decB)
//   LdP               accumulate P <= P + A, guarded by B != 0
//   clrP              clear P, ovf, iter_cnt (beats LdP)
//   decB              decrement B, holding at zero
//   eqz               B == 0, combinational
//   product [2W-1:0]  register P
//   ovf               sticky carry out of P
//   iter_cnt [W-1:0]  accumulates since clrP, saturating
module mul_datapath #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   data_in,
  input  logic           LdA,
  input  logic           LdB,
  input  logic           LdP,
  input  logic           clrP,
  input  logic           decB,
  output logic           eqz,
  output logic [2*W-1:0] product,
  output logic           ovf,
  output logic [W-1:0]   iter_cnt
);

  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] p;
  logic [2*W:0]   sum;
  logic           acc;

  assign eqz     = (b == '0);
  assign product = p;

  // The B != 0 guard drops the controller's last LdP cycle, so the
  // number of additions equals the loaded B exactly.
  assign acc = LdP & ~clrP & ~eqz;
  assign sum = {1'b0, p} + {{(W+1){1'b0}}, a};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a        <= '0;
      b        <= '0;
      p        <= '0;
      ovf      <= 1'b0;
      iter_cnt <= '0;
    end else begin
      if (LdA)
        a <= data_in;

      if (LdB)
        b <= data_in;
      else if (decB && !eqz)
        b <= b - 1'b1;

      if (clrP) begin
        p        <= '0;
        ovf      <= 1'b0;
        iter_cnt <= '0;
      end else if (acc) begin
        p <= sum[2*W-1:0];
        if (sum[2*W])
          ovf <= 1'b1;
        if (iter_cnt != '1)
          iter_cnt <= iter_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_datapath.sv
// Directed + random bench for mul_datapath (W=16) against an
// arithmetic reference model of A, B, P, ovf and the accumulate count.
module tb_mul_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic        LdA, LdB, LdP, clrP, decB;
  logic        eqz;
  logic [31:0] product;
  logic        ovf;
  logic [15:0] iter_cnt;

  int unsigned     vectors = 0;
  int unsigned     miscompares = 0;

  int unsigned     ma, mb, mcnt;
  longint unsigned mp;
  bit              movf;

  mul_datapath #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .LdA(LdA), .LdB(LdB), .LdP(LdP), .clrP(clrP), .decB(decB),
    .eqz(eqz), .product(product), .ovf(ovf), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit la, input bit lb, input bit lp,
                      input bit cp, input bit db, input logic [15:0] d);
    bit              acc;
    longint unsigned s;
    LdA = la; LdB = lb; LdP = lp; clrP = cp; decB = db; data_in = d;
    @(posedge clk);
    if (!rst_n) begin
      ma = 0; mb = 0; mp = 0; movf = 0; mcnt = 0;
    end else begin
      acc = lp && !cp && (mb != 0);
      s = mp + ma;
      if (cp) begin
        mp = 0; movf = 0; mcnt = 0;
      end else if (acc) begin
        mp = s & 64'hFFFF_FFFF;
        if (s > 64'hFFFF_FFFF) movf = 1;
        if (mcnt < 65535) mcnt++;
      end
      if (lb) mb = d;
      else if (db && mb != 0) mb--;
      if (la) ma = d;
    end
    #1;
    chk("product", 64'(product), mp);
    chk("eqz", 64'(eqz), 64'(mb == 0));
    chk("ovf", 64'(ovf), 64'(movf));
    chk("iter_cnt", 64'(iter_cnt), 64'(mcnt));
  endtask

  task automatic run_to_eqz(input int unsigned budget);
    bit done;
    done = 0;
    for (int i = 0; i <= budget; i++) begin
      if (eqz) begin
        done = 1;
        break;
      end
      step(0, 0, 1, 0, 1, 16'h0);
    end
    chk("eqz_budget", 64'(done), 64'd1);
  endtask

  task automatic mul(input logic [15:0] x, input logic [15:0] y);
    step(1, 0, 0, 0, 0, x);
    step(0, 1, 0, 1, 0, y);
    run_to_eqz(int'(y) + 1);
    chk("mul_product", 64'(product), 64'(x) * 64'(y));
    chk("mul_cnt", 64'(iter_cnt), 64'(y));
  endtask

  initial begin
    rst_n = 0;
    {LdA, LdB, LdP, clrP, decB} = '1;
    data_in = 16'hFFFF;
    ma = 0; mb = 0; mp = 0; movf = 0; mcnt = 0;

    step(1, 1, 1, 0, 1, 16'hFFFF);
    chk("rst_eqz", 64'(eqz), 64'd1);
    chk("rst_product", 64'(product), 64'd0);
    rst_n = 1;

    mul(16'd7, 16'd5);
    step(0, 0, 1, 0, 1, 16'h0);
    chk("basic_35", 64'(product), 64'd35);

    step(1, 0, 0, 0, 0, 16'd9);
    step(0, 1, 0, 1, 0, 16'd0);
    repeat (3) step(0, 0, 1, 0, 1, 16'h0);
    chk("zero_b_product", 64'(product), 64'd0);
    chk("zero_b_eqz", 64'(eqz), 64'd1);

    step(0, 1, 0, 1, 0, 16'd9);
    step(0, 1, 0, 0, 1, 16'd4);
    step(1, 0, 0, 0, 0, 16'd3);
    step(0, 0, 1, 1, 0, 16'h0);
    chk("clr_beats_ldp", 64'(product), 64'd0);
    run_to_eqz(6);
    chk("ldb_beats_dec", 64'(product), 64'd12);

    step(1, 0, 0, 1, 0, 16'd2);
    step(0, 1, 0, 0, 0, 16'd1);
    step(1, 0, 1, 0, 0, 16'd8);
    chk("old_a_used", 64'(product), 64'd2);
    step(0, 1, 0, 0, 0, 16'd1);
    step(0, 0, 1, 0, 0, 16'h0);
    chk("new_a_later", 64'(product), 64'd10);

    step(1, 0, 0, 0, 0, 16'd3);
    step(0, 1, 0, 1, 0, 16'd10);
    repeat (4) step(0, 0, 1, 0, 1, 16'h0);
    chk("mid_run_12", 64'(product), 64'd12);
    rst_n = 0;
    step(1, 1, 1, 0, 1, 16'h5A5A);
    rst_n = 1;
    chk("mid_rst_product", 64'(product), 64'd0);
    chk("mid_rst_eqz", 64'(eqz), 64'd1);
    chk("mid_rst_cnt", 64'(iter_cnt), 64'd0);
    mul(16'd2, 16'd6);

    for (int i = 0; i < 20; i++)
      mul(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 30)));
    mul(16'd0, 16'd12);

    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0),
           bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 7) == 0),
           bit'($urandom_range(0, 1)), 16'($urandom));
    end
    rst_n = 1;

    mul(16'hFFFF, 16'hFFFF);
    step(0, 0, 1, 0, 1, 16'h0);
    chk("big_product", 64'(product), 64'hFFFE_0001);
    chk("big_ovf", 64'(ovf), 64'd0);
    chk("cnt_sat", 64'(iter_cnt), 64'hFFFF);
    step(0, 1, 0, 0, 0, 16'd2);
    repeat (2) step(0, 0, 1, 0, 1, 16'h0);
    chk("preload_max", 64'(product), 64'hFFFF_FFFF);
    step(1, 1, 0, 0, 0, 16'd1);
    step(0, 0, 1, 0, 1, 16'h0);
    chk("wrap_product", 64'(product), 64'd0);
    chk("wrap_ovf", 64'(ovf), 64'd1);
    step(0, 1, 0, 0, 0, 16'd1);
    step(0, 0, 1, 0, 1, 16'h0);
    chk("ovf_sticky", 64'(ovf), 64'd1);
    chk("after_wrap", 64'(product), 64'd1);
    step(0, 0, 0, 1, 0, 16'h0);
    chk("clr_ovf", 64'(ovf), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
